uart_receiver: RTL
==================

Name: uart_receiver

Overview:
- Serial-to-parallel receive stage of the UART core; sits directly upstream of the memory-mapped UART register interface and feeds its receive data/valid path.
- Synchronises the asynchronous RX pin, detects and validates the start bit, and samples 8 data bits LSB-first at mid-bit.
- Checks the stop bit and presents each byte through a one-entry holding register with a ready/valid handshake.
- Reports framing errors and overruns as single-cycle pulses.

Parameters:
- CLOCK_FREQ, 125_000_000, clk frequency in Hz.
- BAUD_RATE, 115_200, line rate in bits/s. Derived locally: SYMBOL_EDGE_TIME = CLOCK_FREQ/BAUD_RATE (integer divide); SAMPLE_TIME = SYMBOL_EDGE_TIME/2; CLOCK_COUNTER_WIDTH = $clog2(SYMBOL_EDGE_TIME).

Ports:
- clk  input  1  system clock; one clock domain, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- serial_in  input  1  asynchronous RX line; idles high.
- data_out  output  8  received byte from the holding register.
- data_out_valid  output  1  holding register full.
- data_out_ready  input  1  consumer accepts the byte; transfer occurs when valid & ready.
- framing_error  output  1  one-cycle pulse: stop bit sampled 0.
- overrun  output  1  one-cycle pulse: new byte completed while holding register full and not being drained.

Behaviour:
- Reset: data_out = 8'h00, data_out_valid = 0, framing_error = 0, overrun = 0, state = IDLE, counters = 0. Both synchroniser flops reset to 1 so no false start is seen.
- Synchroniser: two flops on serial_in produce rx_s. All decisions use rx_s, which adds 2 cycles of latency.
- Clock counter: counts 0..SYMBOL_EDGE_TIME-1 and is cleared on every state entry. Bit counter is 3 bits.
- IDLE: when rx_s == 0, go to START.
- START: at count == SAMPLE_TIME-1, if rx_s == 0 go to DATA with the counter cleared; else treat as a glitch and return to IDLE. Nothing is reported for a glitch.
- DATA: at count == SYMBOL_EDGE_TIME-1, sample rx_s into shift[7] and shift right, giving LSB-first order. After the 8th sample go to STOP.
- STOP: at count == SYMBOL_EDGE_TIME-1, sample rx_s.
  - Sample 1, holding register empty or being drained this cycle (valid & ready): load data_out <= shift and set valid = 1 on the next cycle. Return to IDLE.
  - Sample 1, holding register full and ready = 0: pulse overrun. Keep the old data_out; the new byte is dropped. Return to IDLE.
  - Sample 0: pulse framing_error, discard the byte, go to BREAK.
- BREAK: stay until rx_s == 1, then go to IDLE. A held-low line produces exactly one framing_error.
- Handshake: data_out_valid clears on the cycle after valid & ready unless a new byte loads in that same cycle, in which case valid stays 1 with the new data. data_out is stable while valid = 1 and ready = 0.
- Latency: valid rises 1 cycle after the stop-bit sample point, which is about 9.5 bit times plus 3 cycles after the falling start edge on the pin.
- Reset mid-frame: abandons the frame immediately; no valid, error, or overrun is produced.
- Consecutive frames: a start edge immediately after the stop-bit sample is accepted. The half stop bit remaining after sampling is covered by IDLE waiting for rx_s == 0.

Decomposition:
- No shared package typedefs are needed beyond the FSM state encoding. Put localparams IDLE/START/DATA/STOP/BREAK in a shared uart package, since the transmitter reuses IDLE/START/DATA/STOP.
- One natural sub-module: uart_baud_counter, a parameterised counter with clear and terminal-count outputs. The transmitter will instantiate it too.

Test Plan (BAUD_RATE = 1_000_000, CLOCK_FREQ = 125_000_000, i.e. 125 cycles/bit, sample at 62):
- Send 8'hA5 (8N1) with ready held 0 -> data_out = 8'hA5, valid = 1 within 3 cycles after the stop-bit sample; no error pulses.
- Start pulse of 30 cycles low, then high -> stays IDLE; valid, framing_error, and overrun all remain 0.
- Send 8'h3C with stop bit driven 0, then line high -> exactly one framing_error pulse; valid stays 0; next frame 8'h55 is received correctly.
- Send 8'h11 then 8'h22 back-to-back with ready = 0 -> data_out stays 8'h11, one overrun pulse. Then ready = 1 for 1 cycle -> valid drops to 0.
- Send 8'h01 then 8'hFE with ready pulsed exactly on the cycle 8'hFE completes -> valid stays 1 continuously and data_out = 8'hFE.
- Assert reset for 1 cycle in the middle of the DATA bits of 8'hF0 -> no valid or error pulses; the following frame 8'h0F is received correctly.

Source files
------------

// File: rtl/uart_receiver_pkg.sv
// uart_receiver_pkg: FSM state encoding shared by the UART receiver and transmitter
package uart_receiver_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_state_t;
endpackage

// File: rtl/uart_receiver_if.sv
// uart_receiver_if: receive byte handshake and error pulses between receiver (master) and consumer (slave)
// data_out/data_out_valid/framing_error/overrun flow master->slave; data_out_ready flows slave->master
interface uart_receiver_if;
   logic [7:0] data_out;
   logic       data_out_valid;
   logic       data_out_ready;
   logic       framing_error;
   logic       overrun;
   modport master(output data_out, data_out_valid, framing_error, overrun, input data_out_ready);
   modport slave(input data_out, data_out_valid, framing_error, overrun, output data_out_ready);
endinterface

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: bit-period counter 0..TERMINAL-1 with clear and terminal-count flag
// ports: clk, reset (sync, active high), clear (restart at 0), count, tc (count == TERMINAL-1)
module uart_baud_counter #(
   parameter int TERMINAL = 125,
   parameter int WIDTH    = $clog2(TERMINAL)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   output logic [WIDTH-1:0] count,
   output logic             tc
);
   assign tc = count == WIDTH'(TERMINAL - 1);
   always_ff @(posedge clk)
      if (reset || clear) count <= '0;
      else count <= tc ? '0 : count + 1'b1;
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver with one-entry ready/valid holding register
// ports: clk, reset (sync, active high), serial_in (async RX line, idles high),
//        rx (master side: data_out, data_out_valid, data_out_ready, framing_error, overrun)
module uart_receiver
   import uart_receiver_pkg::*;
#(
   parameter int CLOCK_FREQ = 125_000_000,
   parameter int BAUD_RATE  = 115_200
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             serial_in,
   uart_receiver_if.master  rx
);
   localparam int SYMBOL_EDGE_TIME    = CLOCK_FREQ / BAUD_RATE;
   localparam int SAMPLE_TIME         = SYMBOL_EDGE_TIME / 2;
   localparam int CLOCK_COUNTER_WIDTH = $clog2(SYMBOL_EDGE_TIME);

   uart_state_t                    state, state_next;
   logic                           rx_meta, rx_s;
   logic [CLOCK_COUNTER_WIDTH-1:0] count;
   logic                           tc, mid_start, data_tick, stop_tick, load;
   logic [2:0]                     bit_cnt;
   logic [7:0]                     shift;

   // counter restarts on every state change so each state times from its own entry
   uart_baud_counter #(.TERMINAL(SYMBOL_EDGE_TIME), .WIDTH(CLOCK_COUNTER_WIDTH)) u_baud (
      .clk(clk), .reset(reset), .clear(state_next != state), .count(count), .tc(tc)
   );

   assign mid_start = state == START && count == CLOCK_COUNTER_WIDTH'(SAMPLE_TIME - 1);
   assign data_tick = state == DATA && tc;
   assign stop_tick = state == STOP && tc;
   // a byte may load when the register is empty or is being drained in this same cycle
   assign load = stop_tick && rx_s && (!rx.data_out_valid || rx.data_out_ready);

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    state_next = rx_s ? IDLE : START;
         START:   state_next = mid_start ? (rx_s ? IDLE : DATA) : START;
         DATA:    state_next = data_tick && bit_cnt == 3'd7 ? STOP : DATA;
         STOP:    state_next = stop_tick ? (rx_s ? IDLE : BREAK) : STOP;
         BREAK:   state_next = rx_s ? IDLE : BREAK;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk)
      if (reset) state <= IDLE;
      else state <= state_next;

   always_ff @(posedge clk)
      if (reset) begin
         {rx_s, rx_meta}   <= 2'b11;
         bit_cnt           <= '0;
         shift             <= '0;
         rx.data_out       <= '0;
         rx.data_out_valid <= 1'b0;
         rx.framing_error  <= 1'b0;
         rx.overrun        <= 1'b0;
      end else begin
         {rx_s, rx_meta}   <= {rx_meta, serial_in};
         bit_cnt           <= state != DATA ? '0 : bit_cnt + 3'(data_tick);
         shift             <= data_tick ? {rx_s, shift[7:1]} : shift;
         rx.data_out       <= load ? shift : rx.data_out;
         rx.data_out_valid <= load || (rx.data_out_valid && !rx.data_out_ready);
         rx.framing_error  <= stop_tick && !rx_s;
         rx.overrun        <= stop_tick && rx_s && rx.data_out_valid && !rx.data_out_ready;
      end
endmodule
